// File: rtl/pe_pkg.sv
// Shared types and constants for the NTT processing element.
package pe_pkg;
   localparam int COEF_W = 23;
   localparam logic [COEF_W-1:0] Q_DIL = 23'h7FE001;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      RES,
      DONE
   } bf_state_t;
endpackage

// File: rtl/butterfly_ct_if.sv
// Operand/result handshake bundle for the CT butterfly.
interface butterfly_ct_if
   import pe_pkg::*;
#(
   parameter int W = COEF_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] w;
   logic [W-1:0] q;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a_res;
   logic [W-1:0] b_res;

   modport master (
      output in_valid, a, b, w, q, out_ready,
      input  in_ready, out_valid, a_res, b_res
   );

   modport slave (
      input  in_valid, a, b, w, q, out_ready,
      output in_ready, out_valid, a_res, b_res
   );
endinterface

// File: rtl/mod_mul_iter.sv
// MSB-first interleaved modular multiplier: one bit of w per step.
module mod_mul_iter
   import pe_pkg::*;
#(
   parameter int W = COEF_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         step_i,
   input  logic [W-1:0] w_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] q_i,
   output logic         done_o,
   output logic [W-1:0] t_o
);
   localparam int CW = $clog2(W);

   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  w_q, w_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    dbl;
   logic [W:0]    sum;
   logic [W-1:0]  red;
   logic [W:0]    q_ext;

   assign q_ext = {1'b0, q_i};

   always_comb begin
      dbl   = {acc_q, 1'b0};
      red   = (dbl >= q_ext) ? W'(dbl - q_ext) : dbl[W-1:0];
      sum   = {1'b0, red} + (w_q[W-1] ? {1'b0, b_i} : '0);
      acc_d = acc_q;
      w_d   = w_q;
      cnt_d = cnt_q;
      if (start_i) begin
         acc_d = '0;
         w_d   = w_i;
         cnt_d = CW'(W - 1);
      end else if (step_i) begin
         acc_d = (sum >= q_ext) ? W'(sum - q_ext) : sum[W-1:0];
         w_d   = {w_q[W-2:0], 1'b0};
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);
   assign t_o    = acc_q;
endmodule

// File: rtl/mod_sub.sv
// Modular subtraction (a - b) mod q on 24-bit operands, a,b < q.
module mod_sub (
   input  logic [23:0] a_i,
   input  logic [23:0] b_i,
   input  logic [23:0] q_i,
   output logic [23:0] r_o
);
   // a + (q - b) cannot overflow when a < b < q
   assign r_o = (a_i >= b_i) ? (a_i - b_i)
                             : (a_i + (q_i - b_i));
endmodule

// File: rtl/butterfly_ct.sv
// Cooley-Tukey butterfly: a +/- w*b mod q with iterative multiply.
module butterfly_ct
   import pe_pkg::*;
#(
   parameter int W = COEF_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] w_i,
   input  logic [W-1:0] q_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o
);
   bf_state_t    state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] q_q, q_d;
   logic [W-1:0] ao_q, ao_d;
   logic [W-1:0] bo_q, bo_d;
   logic [W-1:0] t;
   logic         mul_done;
   logic         start;
   logic [W:0]   add_s;
   logic [23:0]  sub_r;

   assign start = (state_q == IDLE) && in_valid_i;

   mod_mul_iter #(.W(W)) u_mul (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start),
      .step_i  (state_q == MUL),
      .w_i     (w_i),
      .b_i     (b_q),
      .q_i     (q_q),
      .done_o  (mul_done),
      .t_o     (t)
   );

   mod_sub u_sub (
      .a_i (24'(a_q)),
      .b_i (24'(t)),
      .q_i (24'(q_q)),
      .r_o (sub_r)
   );

   assign add_s = {1'b0, a_q} + {1'b0, t};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      ao_d    = ao_q;
      bo_d    = bo_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               q_d     = q_i;
               state_d = MUL;
            end
         end
         MUL: begin
            if (mul_done) state_d = RES;
         end
         RES: begin
            ao_d = (add_s >= {1'b0, q_q}) ? W'(add_s - {1'b0, q_q})
                                          : add_s[W-1:0];
            bo_d    = W'(sub_r);
            state_d = DONE;
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         ao_q    <= '0;
         bo_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         ao_q    <= ao_d;
         bo_q    <= bo_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign a_o         = ao_q;
   assign b_o         = bo_q;
endmodule
